// File: rtl/aurora_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : aurora_word_aligner
// Brief    : Comma-based 10-bit word aligner ahead of the per-lane 8b10b decoder.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_word_aligner #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] aligned_data,
    output logic       aligned_valid,
    output logic       aligned_comma,
    output logic       locked,
    output logic [3:0] offset
);

    localparam logic [1:0] c_ST_HUNT   = 2'd0;
    localparam logic [1:0] c_ST_CHECK  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    localparam logic [9:0] c_COMMA_NEG  = 10'b0011111010;
    localparam logic [9:0] c_COMMA_POS  = 10'b1100000101;
    localparam logic [3:0] c_LOCK_COUNT = 4'(LOCK_COUNT);
    localparam logic [3:0] c_ERR_LIMIT  = 4'(ERR_LIMIT);

    logic [1:0]  r_state, w_state_nxt;
    logic [9:0]  r_prev;
    logic        r_prev_ok;
    logic [3:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]  r_err, w_err_nxt, w_err_inc;
    logic [3:0]  r_offset, w_offset_nxt;

    logic [19:0] w_window;
    logic [9:0]  w_cand [10];
    logic [9:0]  w_match;
    logic        w_det_en;
    logic        w_any;
    logic [3:0]  w_first_k;
    logic        w_at_offset;
    logic        w_out_valid;
    logic [9:0]  w_out_data;
    logic        w_out_comma;

    assign w_window = {r_prev, rx_data};
    assign w_det_en = rx_valid & r_prev_ok;

    generate
        for (genvar gk = 0; gk < 10; gk++) begin : g_cand
            assign w_cand[gk]  = w_window[19-gk -: 10];
            assign w_match[gk] = w_det_en &&
                                 ((w_cand[gk] == c_COMMA_NEG) || (w_cand[gk] == c_COMMA_POS));
        end
    endgenerate

    // Lowest matching offset wins: scan downwards so the last hit is the smallest k.
    always_comb begin
        w_any     = 1'b0;
        w_first_k = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (w_match[k]) begin
                w_any     = 1'b1;
                w_first_k = 4'(k);
            end
        end
    end

    assign w_at_offset = w_match[r_offset];
    assign w_cnt_inc   = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    assign w_err_inc   = (r_err == 4'hF) ? r_err : r_err + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_HUNT;
            r_prev    <= 10'd0;
            r_prev_ok <= 1'b0;
            r_cnt     <= 4'd0;
            r_err     <= 4'd0;
            r_offset  <= 4'd0;
        end else if (rx_valid) begin
            r_state   <= w_state_nxt;
            r_prev    <= rx_data;
            r_prev_ok <= 1'b1;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_offset  <= w_offset_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_offset_nxt = r_offset;
        case (r_state)
            c_ST_HUNT: begin
                if (w_any) begin
                    w_offset_nxt = w_first_k;
                    w_cnt_nxt    = 4'd1;
                    w_state_nxt  = (c_LOCK_COUNT == 4'd1) ? c_ST_LOCKED : c_ST_CHECK;
                end
            end
            c_ST_CHECK: begin
                if (w_at_offset) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_LOCK_COUNT) begin
                        w_state_nxt = c_ST_LOCKED;
                    end
                end else if (w_any) begin
                    w_offset_nxt = w_first_k;
                    w_cnt_nxt    = 4'd1;
                end
            end
            c_ST_LOCKED: begin
                if (w_at_offset) begin
                    w_err_nxt = 4'd0;
                end else if (w_any) begin
                    w_err_nxt = w_err_inc;
                    if (w_err_inc == c_ERR_LIMIT) begin
                        w_state_nxt = c_ST_HUNT;
                        w_cnt_nxt   = 4'd0;
                        w_err_nxt   = 4'd0;
                    end
                end
            end
            default: w_state_nxt = c_ST_HUNT;
        endcase
    end

    // The word seen on the cycle that leaves LOCKED is still emitted, since output keys off the current state.
    always_comb begin
        w_out_valid = rx_valid && (r_state == c_ST_LOCKED);
        w_out_data  = w_cand[r_offset];
        w_out_comma = w_match[r_offset];
        locked      = (r_state == c_ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aligned_data  <= 10'd0;
            aligned_valid <= 1'b0;
            aligned_comma <= 1'b0;
        end else begin
            aligned_valid <= w_out_valid;
            aligned_comma <= w_out_valid & w_out_comma;
            if (w_out_valid) begin
                aligned_data <= w_out_data;
            end
        end
    end

    assign offset = r_offset;

endmodule
`default_nettype wire

// File: doc/aurora_word_aligner.md
AURORA_WORD_ALIGNER -- requirements
Module: aurora_word_aligner

Receive-side stage: it consumes the unaligned 10-bit words from the lane deserializer. Its aligned output feeds the per-lane 8b10b decoder, which is the mirror of the transmit encode stage.

Interface
REQ-001 Parameter LOCK_COUNT, default 3: number of consecutive commas at the same offset needed to lock (range 1..15).
REQ-002 Parameter ERR_LIMIT, default 4: number of misaligned commas while locked that forces re-hunt (range 1..15).
REQ-003 clk  in  1  single clock; all logic SHALL be on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  10  raw deserialized bits; bit 9 is received first.
REQ-006 rx_valid  in  1  rx_data is valid this cycle.
REQ-007 aligned_data  out  10  realigned code group; bit 9 is first.
REQ-008 aligned_valid  out  1  aligned_data is valid; only asserted while locked.
REQ-009 aligned_comma  out  1  aligned_data is K28.5.
REQ-010 locked  out  1  alignment achieved.
REQ-011 offset  out  4  current bit offset, 0..9.

Function
REQ-012 Window: the block SHALL hold prev (last valid rx_data) and a prev_ok flag; window w[19:0] = {prev, rx_data}; candidate word(k) = w[19-k:10-k], k=0..9.
REQ-013 Comma match: word(k) == 10'b0011111010 or 10'b1100000101; among matches the lowest k SHALL win; detection SHALL be disabled when rx_valid=0 or prev_ok=0.
REQ-014 On each rx_valid cycle the block SHALL set prev <= rx_data and prev_ok <= 1; with rx_valid=0 all state holds and aligned_valid=0 next cycle.
REQ-015 FSM states: HUNT, CHECK, LOCKED; reset state is HUNT.
REQ-016 HUNT, comma at k: offset<=k and cnt<=1; go to LOCKED if LOCK_COUNT=1, otherwise go to CHECK.
REQ-017 CHECK, comma at offset: cnt+1; go to LOCKED when cnt+1 == LOCK_COUNT.
REQ-018 CHECK, comma at k≠offset: offset<=k and cnt<=1; stay in CHECK.
REQ-019 CHECK, non-comma word: no change.
REQ-020 LOCKED, comma at offset: err<=0.
REQ-021 LOCKED, comma only at k≠offset: err+1; when err+1 == ERR_LIMIT, go to HUNT with cnt=0 and err=0; offset holds until the next comma.
REQ-022 LOCKED, non-comma word: err unchanged.
REQ-023 A comma at offset SHALL take precedence over matches at other offsets; such a cycle is not an error.
REQ-024 locked SHALL be 1 iff state==LOCKED, registered.
REQ-025 Output latency: on an rx_valid cycle with state LOCKED, the next cycle SHALL show aligned_data = word(offset), aligned_valid=1, and aligned_comma = match of that word. The cycle that enters LOCKED produces no output.
REQ-026 On the cycle that leaves LOCKED, the word of that same cycle is still output; aligned_valid SHALL be 0 from the following valid word on.
REQ-027 cnt and err SHALL be 4-bit and SHALL saturate; they never wrap.

Reset
REQ-028 With rst=1 at a clock edge, the next cycle SHALL show: state HUNT; prev, prev_ok, cnt, err, offset = 0; aligned_data = 0; aligned_valid, aligned_comma, locked = 0.
REQ-029 Reset SHALL override rx_valid and all FSM activity in any state, including mid-lock.
REQ-030 The first valid word after reset SHALL never produce a comma match (prev_ok=0).

Verification
REQ-031 Offset 0 lock: after reset, send 3 × 0x0FA (K28.5 RD-) then 0x2AA, all valid -> locked rises the cycle after the 3rd comma, offset=0; next cycle aligned_data=0x2AA, aligned_valid=1, aligned_comma=0.
REQ-032 Offset 3 lock: a serial stream of commas delayed 3 bits -> offset=3, locked after LOCK_COUNT commas; aligned_data alternates 0x0FA/0x305 per disparity, with aligned_comma=1 on each.
REQ-033 Offset change in CHECK: 2 commas at k=0, then commas at k=5 -> cnt restarts, lock at offset 5 after 3 commas at k=5.
REQ-034 Loss of lock: locked at k=0, then 4 commas only at k=2 -> locked=0 after the 4th; re-lock at k=2 after 3 further commas. With 3 misaligned commas, then 1 aligned comma, then 3 more misaligned -> lock is held.
REQ-035 Gaps and first word: rx_valid toggled 1/0 during lock -> aligned_valid follows 1 cycle later and the data stream is unbroken. A first post-reset word of 0x0FA -> no match.
REQ-036 Reset mid-lock: assert rst while LOCKED -> all outputs 0 next cycle; re-lock requires LOCK_COUNT fresh commas.
